// File: rtl/instr_reader_pkg.sv
// Reader-side additions: sequencer states and the widths of the reader's
// run-length and mismatch counters.
package instr_reader_pkg;

    localparam int DEPTH   = 32;
    localparam int CNT_W   = 8;
    localparam int COUNT_W = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } reader_state_t;

endpackage

// File: rtl/instr_register_pkg.sv
// Shared types of the 32-entry instruction register: operands, opcodes,
// register addresses and the stored instruction record.
package instr_register_pkg;

    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] result_t;
    typedef logic        [4:0]  address_t;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  res;
    } instruction_t;

endpackage

// File: rtl/instr_reader_result_model.sv
// Reference arithmetic for one instruction: the result the register should
// have stored, plus a flag for divide/modulo by zero (result not checkable).
module instr_result_model
    import instr_register_pkg::*;
(
    input  opcode_t  opcode,
    input  operand_t op_a,
    input  operand_t op_b,
    output result_t  expected,
    output logic     div0
);

    result_t w_a;
    result_t w_b;

    // Everything is evaluated at 64 bits so ADD/SUB/MULT never truncate.
    always_comb begin
        w_a      = {{32{op_a[31]}}, op_a};
        w_b      = {{32{op_b[31]}}, op_b};
        expected = 64'sd0;
        div0     = 1'b0;
        case (opcode)
            ZERO:  expected = 64'sd0;
            PASSA: expected = w_a;
            PASSB: expected = w_b;
            ADD:   expected = w_a + w_b;
            SUB:   expected = w_a - w_b;
            MULT:  expected = w_a * w_b;
            DIV: begin
                if (w_b == 64'sd0) begin
                    div0     = 1'b1;
                    expected = 64'sd0;
                end else begin
                    expected = w_a / w_b;
                end
            end
            MOD: begin
                if (w_b == 64'sd0) begin
                    div0     = 1'b1;
                    expected = 64'sd0;
                end else begin
                    expected = w_a % w_b;
                end
            end
            default: expected = 64'sd0;
        endcase
    end

endmodule

// File: rtl/instr_reader.sv
// Read-side sequencer: walks the instruction register over an address window,
// presents each entry on valid/ready and flags results that fail re-computation.
module instr_reader
    import instr_register_pkg::*;
    import instr_reader_pkg::*;
#(
    parameter int DEPTH_P = DEPTH,
    parameter int CNT_W_P = CNT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  address_t           start_addr,
    input  logic [COUNT_W-1:0] count,
    output address_t           read_pointer,
    input  instruction_t       instruction_word,
    output logic               out_valid,
    input  logic               out_ready,
    output instruction_t       out_instr,
    output logic               out_mismatch,
    output logic               out_div0,
    output logic               busy,
    output logic               done,
    output logic [CNT_W_P-1:0] mismatch_count
);

    reader_state_t      r_state;
    address_t           r_read_pointer;
    logic [COUNT_W-1:0] r_remaining;
    instruction_t       r_out_instr;
    logic               r_out_valid;
    logic               r_out_mismatch;
    logic               r_out_div0;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W_P-1:0] r_mismatch_count;

    result_t w_expected;
    logic    w_div0;
    logic    w_mismatch;

    instr_result_model u_model (
        .opcode   (instruction_word.opc),
        .op_a     (instruction_word.op_a),
        .op_b     (instruction_word.op_b),
        .expected (w_expected),
        .div0     (w_div0)
    );

    // Case inequality so that any X/Z bit in the stored result reads as a mismatch.
    assign w_mismatch = (instruction_word.res !== w_expected) && !w_div0;

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= IDLE;
            r_read_pointer   <= 5'd0;
            r_remaining      <= {COUNT_W{1'b0}};
            r_out_instr      <= '0;
            r_out_valid      <= 1'b0;
            r_out_mismatch   <= 1'b0;
            r_out_div0       <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_mismatch_count <= {CNT_W_P{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start && (count != 6'd0)) begin
                        r_read_pointer   <= start_addr;
                        r_remaining      <= count;
                        r_mismatch_count <= {CNT_W_P{1'b0}};
                        r_busy           <= 1'b1;
                        r_state          <= FETCH;
                    end else if (start) begin
                        r_busy  <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                FETCH: begin
                    r_out_instr    <= instruction_word;
                    r_out_valid    <= 1'b1;
                    r_out_mismatch <= w_mismatch;
                    r_out_div0     <= w_div0;
                    if (w_mismatch && (r_mismatch_count != {CNT_W_P{1'b1}})) begin
                        r_mismatch_count <= r_mismatch_count + CNT_W_P'(1);
                    end else begin
                        r_mismatch_count <= r_mismatch_count;
                    end
                    r_state <= PRESENT;
                end
                PRESENT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_remaining <= r_remaining - 6'd1;
                        if (r_remaining == 6'd1) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_read_pointer <= (r_read_pointer == address_t'(DEPTH_P - 1))
                                              ? 5'd0 : r_read_pointer + 5'd1;
                            r_state        <= FETCH;
                        end
                    end else begin
                        r_state <= PRESENT;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign read_pointer   = r_read_pointer;
    assign out_instr      = r_out_instr;
    assign out_valid      = r_out_valid;
    assign out_mismatch   = r_out_mismatch;
    assign out_div0       = r_out_div0;
    assign busy           = r_busy;
    assign done           = r_done;
    assign mismatch_count = r_mismatch_count;

endmodule

// File: doc/instr_reader.md
Name: instr_reader

Overview:
- Read-side sequencer for the 32-entry instruction register.
- On a start command it walks the register's read_pointer over a contiguous address window, one entry at a time.
- Each captured instruction_word is offered downstream on a valid/ready interface.
- An independently recomputed expected result is compared against the stored result and mismatches are flagged and counted. Used as the RTL checker/drain stage in the lab testbench.

Parameters:
- DEPTH, 32, number of register entries; address wraps modulo DEPTH.
- CNT_W, 8, width of the saturating mismatch counter.

Ports:
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  start request, sampled in IDLE only
- start_addr  input  address_t (5)  first entry to read
- count  input  6  entries to read, 0..32
- read_pointer  output  address_t (5)  drives the instruction register read address
- instruction_word  input  instruction_t  combinational read data from the instruction register
- out_valid  output  1  out_instr valid
- out_ready  input  1  downstream accepts
- out_instr  output  instruction_t  captured entry
- out_mismatch  output  1  stored res differs from expected; qualified by out_valid
- out_div0  output  1  DIV/MOD with op_b==0; check skipped
- busy  output  1  not IDLE
- done  output  1  one-cycle pulse at end of run
- mismatch_count  output  CNT_W  saturating mismatch count for the current run

Behaviour:
Reset (asynchronous):
- State goes to IDLE.
- read_pointer, out_instr, and mismatch_count are cleared to 0.
- out_valid, out_mismatch, out_div0, busy, and done are cleared to 0.

FSM states are IDLE, FETCH, PRESENT, and DONE.

IDLE:
- start=1 with count>0 loads read_pointer<=start_addr and remaining<=count, clears mismatch_count, and moves to FETCH.
- start=1 with count==0 moves to DONE; no entries are output.

FETCH:
- instruction_word is stable at this point because read_pointer was registered the previous cycle.
- Capture it into out_instr.
- Set out_valid=1, out_mismatch, and out_div0.
- Increment mismatch_count on a mismatch; it saturates at all-ones.
- Move to PRESENT.

PRESENT:
- out_valid is held at 1 and out_instr is held stable until out_ready=1.
- On accept, decrement remaining and drop out_valid.
  - If remaining was 1, move to DONE.
  - Otherwise read_pointer<=read_pointer+1 (31 wraps to 0) and move to FETCH.

DONE:
- done=1 for exactly one cycle, then move to IDLE.
- mismatch_count holds until the next accepted start.

Throughput and latency:
- Maximum throughput is one entry per 2 cycles.
- The first out_valid appears 2 cycles after start is sampled.

Concurrency rules:
- start while busy is ignored.
- out_ready while out_valid=0 is ignored.
- reset_n low mid-run aborts immediately. No done pulse is generated, and any pending output is dropped.

Expected result (computed from the captured op_a and op_b, signed 32-bit; res is signed 64-bit):
- PASSA gives op_a sign-extended.
- PASSB gives op_b sign-extended.
- ADD and SUB are computed at 64-bit width after sign-extension, so there is no 32-bit overflow truncation.
- MULT gives the full signed 64-bit product.
- DIV and MOD are signed, truncating toward zero.
  - If op_b==0: out_div0=1, out_mismatch=0, counter unchanged.
- ZERO and any undefined opcode give 0.
- out_mismatch = (res != expected). Any X/Z bit in res counts as a mismatch.

Decomposition:
- instr_register_pkg (existing) supplies operand_t, opcode_t, address_t, instruction_t, and result_t.
- Add to the package:
  - reader_state_t enum {IDLE, FETCH, PRESENT, DONE}
  - localparam for the count width.
- Sub-module instr_result_model: purely combinational.
  - Inputs: opcode, op_a, op_b.
  - Outputs: expected (result_t) and div0.
  - Reused by the SV testbench scoreboard.

Test Plan:
1. Reset, load entries 0..3 with PASSA(5,9), PASSB(5,9), ADD(7,-3), MULT(-4,6); start_addr=0, count=4, out_ready=1 -> res 5, 9, 4, -24. All out_mismatch=0, mismatch_count=0, done one cycle after the 4th accept.
2. Same run with out_ready held low 5 cycles at entry 2 -> out_valid high throughout, out_instr unchanged, read_pointer stays 2.
3. SUB(10,4) loaded by the current register (stores 3) -> expected 6, out_mismatch=1, mismatch_count=1.
4. start_addr=30, count=4 -> read_pointer sequence 30, 31, 0, 1, then done.
5. DIV(8,0) and MOD(8,0) -> out_div0=1, out_mismatch=0. DIV(-7,2) gives -3 and MOD(-7,2) gives -1, both with no mismatch.
6. count=0 -> done 1 cycle later, out_valid never set.
7. reset_n asserted during PRESENT -> all outputs 0 asynchronously, no done pulse.
8. start pulsed while busy -> ignored.
